// File: rtl/rx_lane_unstriping_pkg.sv
// Shared symbol bytes, control_dk codes and framing states for the receive unstriping path.
// The control_dk encoding is common with the transmitter mux.
package rx_lane_unstriping_pkg;

  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_SKP  = 8'h1C;
  localparam logic [7:0] SYM_STP  = 8'hFB;
  localparam logic [7:0] SYM_SDP  = 8'h5C;
  localparam logic [7:0] SYM_END  = 8'hFD;
  localparam logic [7:0] SYM_EDB  = 8'hFE;
  localparam logic [7:0] SYM_FTS  = 8'h3C;
  localparam logic [7:0] SYM_IDLE = 8'h7C;

  // FIFO word: {k[3:0], lane3, lane2, lane1, lane0}
  localparam int unsigned WORD_W = 36;

  typedef enum logic [3:0] {
    DK_DATA = 4'b0000,
    DK_COM  = 4'b0001,
    DK_SKP  = 4'b0010,
    DK_STP  = 4'b0011,
    DK_SDP  = 4'b0100,
    DK_END  = 4'b0101,
    DK_EDB  = 4'b0110,
    DK_FTS  = 4'b0111,
    DK_IDLE = 4'b1000,
    DK_BADK = 4'b1111
  } dk_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TLP  = 2'd1,
    S_DLLP = 2'd2
  } frame_state_e;

  function automatic dk_code_e classify(input logic [7:0] sym, input logic is_k);
    dk_code_e code;
    code = DK_DATA;
    if (is_k) begin
      case (sym)
        SYM_COM:  code = DK_COM;
        SYM_SKP:  code = DK_SKP;
        SYM_STP:  code = DK_STP;
        SYM_SDP:  code = DK_SDP;
        SYM_END:  code = DK_END;
        SYM_EDB:  code = DK_EDB;
        SYM_FTS:  code = DK_FTS;
        SYM_IDLE: code = DK_IDLE;
        default:  code = DK_BADK;
      endcase
    end else begin
      code = DK_DATA;
    end
    return code;
  endfunction

endpackage

// File: rtl/rx_lane_unstriping_if.sv
// Bundle of the striped lane input and the serialised byte output of rx_lane_unstriping.
// master = link side driving lanes and consuming bytes; slave = the unstriping block.
interface rx_lane_unstriping_if;

  logic [7:0] rx_lane0;
  logic [7:0] rx_lane1;
  logic [7:0] rx_lane2;
  logic [7:0] rx_lane3;
  logic [3:0] rx_lane_k;
  logic       rx_lane_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic [3:0] rx_control_dk;
  logic       rx_valid;
  logic       pkt_start;
  logic       pkt_end;
  logic       pkt_err;
  logic       fifo_ovf;

  modport master (
    output rx_lane0, rx_lane1, rx_lane2, rx_lane3, rx_lane_k, rx_lane_valid,
    input  rx_ready, rx_data, rx_control_dk, rx_valid, pkt_start, pkt_end, pkt_err, fifo_ovf
  );

  modport slave (
    input  rx_lane0, rx_lane1, rx_lane2, rx_lane3, rx_lane_k, rx_lane_valid,
    output rx_ready, rx_data, rx_control_dk, rx_valid, pkt_start, pkt_end, pkt_err, fifo_ovf
  );

endinterface

// File: rtl/rx_lane_unstriping_fifo.sv
// rx_word_fifo: small synchronous word FIFO holding striped words plus their K flags.
// Writes while full and reads while empty are ignored; no write-through when full.
module rx_word_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             wr_fire_s;
  logic             rd_fire_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign wr_fire_s = wr_en_i & ~full_o;
  assign rd_fire_s = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage array, written only on an accepted word
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_fire_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({wr_fire_s, rd_fire_s})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rx_lane_unstriping.sv
// Receive lane unstriping: buffers 4-lane words, re-serialises one byte per cycle,
// classifies each byte, drops SKP and checks STP/SDP..END/EDB framing.
module rx_lane_unstriping
  import rx_lane_unstriping_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  rx_lane_unstriping_if.slave  bus
);

  logic [WORD_W-1:0] wr_word_s;
  logic [WORD_W-1:0] head_word_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              pop_s;
  logic [7:0]        lane_byte_s;
  logic              lane_k_s;

  logic [1:0]        lane_ptr_q;
  logic [7:0]        byte_q;
  logic              byte_k_q;
  logic              byte_vld_q;

  dk_code_e          code_s;
  frame_state_e      state_q, state_d;
  logic              emit_d, start_d, end_d, err_d;
  logic              rx_valid_q, pkt_start_q, pkt_end_q, pkt_err_q, fifo_ovf_q;
  logic [7:0]        rx_data_q;
  logic [3:0]        rx_dk_q;

  assign wr_word_s = {bus.rx_lane_k, bus.rx_lane3, bus.rx_lane2, bus.rx_lane1, bus.rx_lane0};
  assign pop_s     = enb & ~fifo_empty_s & (lane_ptr_q == 2'd3);

  rx_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (enb & bus.rx_lane_valid),
    .wr_data_i (wr_word_s),
    .rd_en_i   (pop_s),
    .rd_data_o (head_word_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

  // Select the head-word byte and K flag addressed by the lane pointer
  always_comb begin
    lane_byte_s = head_word_s[7:0];
    lane_k_s    = head_word_s[32];
    case (lane_ptr_q)
      2'd0:    begin lane_byte_s = head_word_s[7:0];   lane_k_s = head_word_s[32]; end
      2'd1:    begin lane_byte_s = head_word_s[15:8];  lane_k_s = head_word_s[33]; end
      2'd2:    begin lane_byte_s = head_word_s[23:16]; lane_k_s = head_word_s[34]; end
      2'd3:    begin lane_byte_s = head_word_s[31:24]; lane_k_s = head_word_s[35]; end
      default: begin lane_byte_s = head_word_s[7:0];   lane_k_s = head_word_s[32]; end
    endcase
  end

  // Serialiser stage: one byte per enabled cycle; pointer held while FIFO is empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_ptr_q <= 2'd0;
      byte_q     <= 8'h00;
      byte_k_q   <= 1'b0;
      byte_vld_q <= 1'b0;
    end else if (enb) begin
      if (!fifo_empty_s) begin
        byte_q     <= lane_byte_s;
        byte_k_q   <= lane_k_s;
        byte_vld_q <= 1'b1;
        lane_ptr_q <= lane_ptr_q + 2'd1;
      end else begin
        byte_vld_q <= 1'b0;
      end
    end
  end

  assign code_s = classify(byte_q, byte_k_q);

  // Framing next-state and pulse decode; SKP never reaches the framing logic
  always_comb begin
    state_d = state_q;
    emit_d  = 1'b0;
    start_d = 1'b0;
    end_d   = 1'b0;
    err_d   = 1'b0;
    if (enb && byte_vld_q && (code_s != DK_SKP)) begin
      emit_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          case (code_s)
            DK_STP:                  begin state_d = S_TLP;  start_d = 1'b1; end
            DK_SDP:                  begin state_d = S_DLLP; start_d = 1'b1; end
            DK_COM, DK_IDLE, DK_FTS: state_d = S_IDLE;
            default:                 err_d = 1'b1;
          endcase
        end
        S_TLP, S_DLLP: begin
          case (code_s)
            DK_DATA: state_d = state_q;
            DK_END:  begin state_d = S_IDLE; end_d = 1'b1; end
            DK_EDB:  begin state_d = S_IDLE; end_d = 1'b1; err_d = 1'b1; end
            DK_STP:  begin state_d = S_TLP;  start_d = 1'b1; err_d = 1'b1; end
            DK_SDP:  begin state_d = S_DLLP; start_d = 1'b1; err_d = 1'b1; end
            default: begin state_d = S_IDLE; err_d = 1'b1; end
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      emit_d = 1'b0;
    end
  end

  // Registered outputs and framing state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_valid_q  <= 1'b0;
      pkt_start_q <= 1'b0;
      pkt_end_q   <= 1'b0;
      pkt_err_q   <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_dk_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= emit_d;
      pkt_start_q <= start_d;
      pkt_end_q   <= end_d;
      pkt_err_q   <= err_d;
      if (emit_d) begin
        rx_data_q <= byte_q;
        rx_dk_q   <= code_s;
      end
    end
  end

  // Overflow flag is sticky until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_ovf_q <= 1'b0;
    end else if (enb && bus.rx_lane_valid && fifo_full_s) begin
      fifo_ovf_q <= 1'b1;
    end
  end

  assign bus.rx_ready      = ~fifo_full_s;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_control_dk = rx_dk_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.pkt_start     = pkt_start_q;
  assign bus.pkt_end       = pkt_end_q;
  assign bus.pkt_err       = pkt_err_q;
  assign bus.fifo_ovf      = fifo_ovf_q;

endmodule
